if_fetch_unit: RTL and testbench

//  Instruction-fetch stage that drives the IF/ID pipeline register: owns the PC, issues in-order

---
 rtl/if_fetch_unit.sv | 147 ++++++++++++++
 tb/tb_if_fetch_unit.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues in-order imem reads, buffers returned words and
// presents the head entry to IF/ID. Define STATIC_PREDICT_EN to enable static JAL/backward-branch prediction.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_addr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction_out,
  output logic [31:0] pc_out,
  output logic        branch_or_not,
  output logic [31:0] calculated_branch_address,
  output logic        valid_out
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_L = (CW+1)'(FIFO_DEPTH);

  logic [31:0]   pc_q;
  logic [31:0]   pcq_mem [FIFO_DEPTH];
  logic [PW-1:0] pcq_rd;
  logic [PW-1:0] pcq_wr;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] discard_cnt;

  logic [31:0]   buf_instr  [FIFO_DEPTH];
  logic [31:0]   buf_pc     [FIFO_DEPTH];
  logic          buf_pred   [FIFO_DEPTH];
  logic [31:0]   buf_target [FIFO_DEPTH];
  logic [PW-1:0] buf_rd;
  logic [PW-1:0] buf_wr;
  logic [CW-1:0] buf_count;

  logic [CW:0]   in_use;
  logic          fire;
  logic          resp;
  logic          accept;
  logic          pop;
  logic [31:0]   resp_pc;
  logic [CW-1:0] out_next;
  logic          pred_taken;
  logic [31:0]   pred_target;

  // Outstanding requests count against buffer space so every response always has a slot.
  assign in_use    = {1'b0, outstanding} + {1'b0, buf_count};
  assign imem_req  = !reset && !redirect_valid && (in_use < DEPTH_L);
  assign imem_addr = pc_q;
  assign fire      = imem_req && imem_gnt;
  assign resp      = imem_rvalid && (outstanding != '0);
  assign accept    = resp && (discard_cnt == '0) && !redirect_valid;
  assign resp_pc   = pcq_mem[pcq_rd];
  assign out_next  = outstanding + CW'(fire) - CW'(resp);
  assign valid_out = (buf_count != '0);
  assign pop       = valid_out && !stall;

`ifdef STATIC_PREDICT_EN
  logic        is_jal;
  logic        is_bwd_branch;
  logic [31:0] imm_j;
  logic [31:0] imm_b;

  assign is_jal        = (imem_rdata[6:0] == 7'b1101111);
  assign is_bwd_branch = (imem_rdata[6:0] == 7'b1100011) && imem_rdata[31];
  assign imm_j = {{12{imem_rdata[31]}}, imem_rdata[19:12], imem_rdata[20], imem_rdata[30:21], 1'b0};
  assign imm_b = {{20{imem_rdata[31]}}, imem_rdata[7], imem_rdata[30:25], imem_rdata[11:8], 1'b0};

  always_comb begin
    pred_taken  = 1'b0;
    pred_target = 32'h0;
    if (is_jal) begin
      pred_taken  = 1'b1;
      pred_target = resp_pc + imm_j;
    end else if (is_bwd_branch) begin
      pred_taken  = 1'b1;
      pred_target = resp_pc + imm_b;
    end
  end
`else
  assign pred_taken  = 1'b0;
  assign pred_target = 32'h0;
`endif

  // Redirect outranks a predicted jump, which outranks sequential advance.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q        <= RESET_PC;
      pcq_rd      <= '0;
      pcq_wr      <= '0;
      outstanding <= '0;
      discard_cnt <= '0;
      buf_rd      <= '0;
      buf_wr      <= '0;
      buf_count   <= '0;
    end else begin
      outstanding <= out_next;
      if (fire) pcq_wr <= pcq_wr + 1'b1;
      if (resp) pcq_rd <= pcq_rd + 1'b1;

      if (redirect_valid) begin
        pc_q        <= redirect_addr;
        discard_cnt <= out_next;
      end else if (accept && pred_taken) begin
        pc_q        <= pred_target;
        discard_cnt <= out_next;
      end else begin
        if (fire) pc_q <= pc_q + 32'd4;
        if (resp && (discard_cnt != '0)) discard_cnt <= discard_cnt - 1'b1;
      end

      if (redirect_valid) begin
        buf_rd    <= '0;
        buf_wr    <= '0;
        buf_count <= '0;
      end else begin
        if (accept) buf_wr <= buf_wr + 1'b1;
        if (pop)    buf_rd <= buf_rd + 1'b1;
        buf_count <= buf_count + CW'(accept) - CW'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (fire) pcq_mem[pcq_wr] <= pc_q;
    if (accept) begin
      buf_instr[buf_wr]  <= imem_rdata;
      buf_pc[buf_wr]     <= resp_pc;
      buf_pred[buf_wr]   <= pred_taken;
      buf_target[buf_wr] <= pred_target;
    end
  end

  assign instruction_out           = valid_out ? buf_instr[buf_rd]  : NOP_INSTR;
  assign pc_out                    = valid_out ? buf_pc[buf_rd]     : 32'h0;
  assign branch_or_not             = valid_out ? buf_pred[buf_rd]   : 1'b0;
  assign calculated_branch_address = valid_out ? buf_target[buf_rd] : 32'h0;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed self-checking bench for if_fetch_unit with a latency-configurable in-order imem model.
// Prediction checks follow STATIC_PREDICT_EN, matching the build of the design.
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_addr;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] instruction_out;
  logic [31:0] pc_out;
  logic        branch_or_not;
  logic [31:0] calculated_branch_address;
  logic        valid_out;

  int checks   = 0;
  int failures = 0;
  int mem_latency = 1;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mem_req_t;

  mem_req_t    resp_q [$];
  logic [31:0] mem_words [logic [31:0]];
  logic [31:0] grant_log [$];
  logic [31:0] pop_pc [$];
  logic [31:0] pop_instr [$];
  logic [31:0] pop_pred [$];
  logic [31:0] pop_target [$];

  if_fetch_unit dut (
    .clk                       (clk),
    .reset                     (reset),
    .stall                     (stall),
    .redirect_valid            (redirect_valid),
    .redirect_addr             (redirect_addr),
    .imem_req                  (imem_req),
    .imem_addr                 (imem_addr),
    .imem_gnt                  (imem_gnt),
    .imem_rvalid               (imem_rvalid),
    .imem_rdata                (imem_rdata),
    .instruction_out           (instruction_out),
    .pc_out                    (pc_out),
    .branch_or_not             (branch_or_not),
    .calculated_branch_address (calculated_branch_address),
    .valid_out                 (valid_out)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    if (mem_words.exists(a)) return mem_words[a];
    return 32'h0000_0013;
  endfunction

  // In-order memory: a grant at an edge answers mem_latency cycles later; ignores reset on purpose.
  always @(posedge clk) begin : imem_model
    static int cyc = 0;
    mem_req_t r;
    cyc++;
    if (imem_req && imem_gnt) begin
      r.addr = imem_addr;
      r.due  = cyc + mem_latency - 1;
      resp_q.push_back(r);
    end
    if (resp_q.size() > 0 && resp_q[0].due <= cyc) begin
      imem_rvalid <= 1'b1;
      imem_rdata  <= memWord(resp_q[0].addr);
      void'(resp_q.pop_front());
    end else begin
      imem_rvalid <= 1'b0;
      imem_rdata  <= 32'h0;
    end
  end

  always @(posedge clk) begin : monitor
    if (!reset) begin
      if (imem_req && imem_gnt) grant_log.push_back(imem_addr);
      if (valid_out && !stall) begin
        pop_pc.push_back(pc_out);
        pop_instr.push_back(instruction_out);
        pop_pred.push_back({31'h0, branch_or_not});
        pop_target.push_back(calculated_branch_address);
      end
    end
  end

  function automatic logic [31:0] logAt(input logic [31:0] q [$], input int i);
    if (i < q.size()) return q[i];
    return 32'hxxxx_xxxx;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic rv, input logic [31:0] ra, input logic g);
    stall          = s;
    redirect_valid = rv;
    redirect_addr  = ra;
    imem_gnt       = g;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clearLogs();
    grant_log.delete();
    pop_pc.delete();
    pop_instr.delete();
    pop_pred.delete();
    pop_target.delete();
  endtask

  // Holds reset long enough for any in-flight model responses to drain, then releases at a negedge.
  task automatic doReset(input int lat, input logic s);
    reset = 1'b1;
    applyStimulus(s, 1'b0, 32'h0, 1'b1);
    cycles(4);
    clearLogs();
    mem_latency = lat;
    reset = 1'b0;
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_req"},    {31'h0, imem_req}, 32'h0);
    checkOutput({tag, "_valid"},  {31'h0, valid_out}, 32'h0);
    checkOutput({tag, "_instr"},  instruction_out, 32'h0000_0013);
    checkOutput({tag, "_pc"},     pc_out, 32'h0);
    checkOutput({tag, "_pred"},   {31'h0, branch_or_not}, 32'h0);
    checkOutput({tag, "_target"}, calculated_branch_address, 32'h0);
  endtask

  initial begin
    mem_words[32'h10] = 32'hFE00_0CE3;
    mem_words[32'h20] = 32'h0080_006F;
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    cycles(2);
    checkResetOutputs("reset");

    $display("[TB] sequential fetch, 1-cycle memory");
    doReset(1, 1'b0);
    #1;
    checkOutput("seq_c0_req", {31'h0, imem_req}, 32'h1);
    checkOutput("seq_c0_addr", imem_addr, 32'h0);
    cycles(1);
    checkOutput("seq_c1_addr", imem_addr, 32'h4);
    checkOutput("seq_c1_valid", {31'h0, valid_out}, 32'h0);
    cycles(1);
    checkOutput("seq_c2_valid", {31'h0, valid_out}, 32'h1);
    checkOutput("seq_c2_pc", pc_out, 32'h0);
    checkOutput("seq_c2_instr", instruction_out, 32'h0000_0013);
    cycles(12);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("seq_grant%0d", i), logAt(grant_log, i), 32'(i * 4));
      checkOutput($sformatf("seq_pop%0d", i), logAt(pop_pc, i), 32'(i * 4));
    end

    $display("[TB] stall holds head and throttles requests");
    doReset(1, 1'b1);
    cycles(7);
    checkOutput("stall_req", {31'h0, imem_req}, 32'h0);
    checkOutput("stall_valid", {31'h0, valid_out}, 32'h1);
    checkOutput("stall_head_pc", pc_out, 32'h0);
    checkOutput("stall_grants", 32'(grant_log.size()), 32'd2);
    stall = 1'b0;
    cycles(14);
    for (int i = 0; i < 4; i++)
      checkOutput($sformatf("stall_pop%0d", i), logAt(pop_pc, i), 32'(i * 4));

    $display("[TB] redirect with two fetches in flight");
    doReset(3, 1'b0);
    cycles(2);
    applyStimulus(1'b0, 1'b1, 32'h100, 1'b1);
    #1;
    checkOutput("redir_req", {31'h0, imem_req}, 32'h0);
    cycles(1);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("redir_empty", {31'h0, valid_out}, 32'h0);
    cycles(16);
    checkOutput("redir_grant2", logAt(grant_log, 2), 32'h100);
    checkOutput("redir_pop0", logAt(pop_pc, 0), 32'h100);
    checkOutput("redir_pop1", logAt(pop_pc, 1), 32'h104);

    $display("[TB] reset mid-stream with late responses");
    doReset(3, 1'b0);
    cycles(2);
    reset = 1'b1;
    imem_gnt = 1'b0;
    #1;
    checkResetOutputs("midreset");
    cycles(1);
    reset = 1'b0;
    #1;
    checkOutput("midreset_addr", imem_addr, 32'h0);
    checkOutput("midreset_req", {31'h0, imem_req}, 32'h1);
    cycles(2);
    checkOutput("midreset_late_ignored", {31'h0, valid_out}, 32'h0);
    clearLogs();
    imem_gnt = 1'b1;
    cycles(16);
    checkOutput("midreset_pop0", logAt(pop_pc, 0), 32'h0);
    checkOutput("midreset_pop1", logAt(pop_pc, 1), 32'h4);

`ifdef STATIC_PREDICT_EN
    $display("[TB] backward branch predicted taken");
    doReset(1, 1'b0);
    cycles(30);
    checkOutput("bp_pc", logAt(pop_pc, 4), 32'h10);
    checkOutput("bp_instr", logAt(pop_instr, 4), 32'hFE00_0CE3);
    checkOutput("bp_taken", logAt(pop_pred, 4), 32'h1);
    checkOutput("bp_target", logAt(pop_target, 4), 32'h8);
    checkOutput("bp_next_pc", logAt(pop_pc, 5), 32'h8);
    checkOutput("bp_fetch_14", logAt(grant_log, 5), 32'h14);
    checkOutput("bp_refetch", logAt(grant_log, 6), 32'h8);
`else
    $display("[TB] no prediction: JAL fetched sequentially");
    doReset(1, 1'b0);
    cycles(40);
    checkOutput("np_beq_taken", logAt(pop_pred, 4), 32'h0);
    checkOutput("np_jal_pc", logAt(pop_pc, 8), 32'h20);
    checkOutput("np_jal_instr", logAt(pop_instr, 8), 32'h0080_006F);
    checkOutput("np_jal_taken", logAt(pop_pred, 8), 32'h0);
    checkOutput("np_jal_target", logAt(pop_target, 8), 32'h0);
    checkOutput("np_next_pc", logAt(pop_pc, 9), 32'h24);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
